// File: rtl/yuv_upsample_csc.sv
// 4:2:2 YUV pair stream to 4:4:4 RGB pixel stream: 6-tap chroma upsampling
// followed by BT.601 limited-range colour conversion with saturation.
module yuv_upsample_csc #(
    parameter int LINE_PAIRS = 160,
    parameter int INTERP     = 1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_y_even,
    input  logic [7:0] in_y_odd,
    input  logic [7:0] in_u,
    input  logic [7:0] in_v,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_r,
    output logic [7:0] out_g,
    output logic [7:0] out_b,
    output logic       out_last
);
    localparam int CW = $clog2(LINE_PAIRS + 1);
    localparam logic [CW-1:0] ZERO      = {CW{1'b0}};
    localparam logic [CW-1:0] ONE       = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] FILL_LAST = CW'(2);
    localparam logic [CW-1:0] LAST_PAIR = CW'(LINE_PAIRS - 1);

    typedef enum logic [1:0] {S_FILL = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2} state_t;

    function automatic logic [7:0] clip8(input logic signed [31:0] x);
        logic [7:0] r;
        if (x < 32'sd0) r = 8'd0;
        else if (x > 32'sd255) r = 8'd255;
        else r = x[7:0];
        return r;
    endfunction

    function automatic logic [7:0] fir6(input logic [7:0] a0, a1, a2, a3, a4, a5);
        logic signed [19:0] s05, s14, s23, acc, sh;
        s05 = $signed({12'd0, a0}) + $signed({12'd0, a5});
        s14 = $signed({12'd0, a1}) + $signed({12'd0, a4});
        s23 = $signed({12'd0, a2}) + $signed({12'd0, a3});
        acc = (20'sd21 * s05) - (20'sd52 * s14) + (20'sd159 * s23) + 20'sd128;
        sh  = acc >>> 8;
        return clip8({{12{sh[19]}}, sh});
    endfunction

    state_t                state_q, state_d;
    logic [CW-1:0]         in_cnt_q, in_cnt_d;
    logic [1:0]            fl_q, fl_d;
    logic                  pend_q, pend_d, in_ready_q, in_ready_d;
    logic                  shift_s, preload_s, flush_shift_s;
    logic [7:0]            uw_q [6];
    logic [7:0]            vw_q [6];
    logic [7:0]            yew_q [4];
    logic [7:0]            yow_q [4];
    logic                  f_valid_q, f_phase_q, f_last_q;
    logic [7:0]            f_ye_q, f_yo_q, f_ue_q, f_ve_q, f_uo_q, f_vo_q;
    logic [7:0]            uo_s, vo_s, sel_y_s, sel_u_s, sel_v_s;
    logic signed [31:0]    yd_s, ud_s, vd_s;
    logic                  m_valid_q, m_last_q;
    logic signed [31:0]    m_yc_q, m_rv_q, m_gu_q, m_gv_q, m_bu_q;
    logic                  out_valid_q, out_last_q;
    logic [7:0]            out_r_q, out_g_q, out_b_q;
    logic                  accept_s, o_adv_s, m_free_s, m_load_s, f_free_s, f_load_s;

    assign accept_s = in_valid && in_ready_q;
    assign o_adv_s  = !out_valid_q || out_ready;
    assign m_free_s = !m_valid_q || o_adv_s;
    assign m_load_s = f_valid_q && m_free_s;
    assign f_free_s = !f_valid_q || (m_load_s && f_phase_q);
    assign f_load_s = pend_q && f_free_s;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_r     = out_r_q;
    assign out_g     = out_g_q;
    assign out_b     = out_b_q;

    // Row sequencing: window shift requests and next state; pend marks an uncaptured pair at tap 2.
    always_comb begin
        state_d       = state_q;
        in_cnt_d      = in_cnt_q;
        fl_d          = fl_q;
        pend_d        = pend_q && !f_load_s;
        shift_s       = 1'b0;
        preload_s     = 1'b0;
        flush_shift_s = 1'b0;
        case (state_q)
            S_FILL: begin
                if (accept_s) begin
                    shift_s   = 1'b1;
                    preload_s = (in_cnt_q == ZERO);
                    in_cnt_d  = in_cnt_q + ONE;
                    if (in_cnt_q == FILL_LAST) state_d = S_RUN;
                    else state_d = S_FILL;
                end else begin
                    state_d = S_FILL;
                end
            end
            S_RUN: begin
                if (accept_s) begin
                    shift_s  = 1'b1;
                    pend_d   = 1'b1;
                    in_cnt_d = in_cnt_q + ONE;
                    if (in_cnt_q == LAST_PAIR) begin
                        state_d = S_FLUSH;
                        fl_d    = 2'd0;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FLUSH: begin
                // Right edge: re-insert the last chroma sample until the final pair is captured.
                if (f_load_s && (fl_q != 2'd3)) begin
                    shift_s       = 1'b1;
                    flush_shift_s = 1'b1;
                    pend_d        = 1'b1;
                    fl_d          = fl_q + 2'd1;
                end else begin
                    fl_d = fl_q;
                end
                if (out_valid_q && out_ready && out_last_q) begin
                    state_d  = S_FILL;
                    in_cnt_d = ZERO;
                    fl_d     = 2'd0;
                end else begin
                    state_d = S_FLUSH;
                end
            end
            default: state_d = S_FILL;
        endcase
        in_ready_d = !pend_d && (state_d != S_FLUSH);
    end

    // Control state registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_FILL;
            in_cnt_q   <= ZERO;
            fl_q       <= 2'd0;
            pend_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_cnt_q   <= in_cnt_d;
            fl_q       <= fl_d;
            pend_q     <= pend_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Chroma window taps 0..5 = k-2..k+3; Y taps 0..3 = pairs k..k+3.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 6; i++) begin
                uw_q[i] <= 8'd0;
                vw_q[i] <= 8'd0;
            end
            for (int i = 0; i < 4; i++) begin
                yew_q[i] <= 8'd0;
                yow_q[i] <= 8'd0;
            end
        end else if (shift_s) begin
            for (int i = 0; i < 5; i++) begin
                uw_q[i] <= preload_s ? in_u : uw_q[i+1];
                vw_q[i] <= preload_s ? in_v : vw_q[i+1];
            end
            uw_q[5] <= flush_shift_s ? uw_q[5] : in_u;
            vw_q[5] <= flush_shift_s ? vw_q[5] : in_v;
            for (int i = 0; i < 3; i++) begin
                yew_q[i] <= yew_q[i+1];
                yow_q[i] <= yow_q[i+1];
            end
            yew_q[3] <= flush_shift_s ? yew_q[3] : in_y_even;
            yow_q[3] <= flush_shift_s ? yow_q[3] : in_y_odd;
        end else begin
            uw_q[0] <= uw_q[0];
        end
    end

    // Odd-pixel chroma for the pair at tap 2.
    always_comb begin
        if (INTERP != 0) begin
            uo_s = fir6(uw_q[0], uw_q[1], uw_q[2], uw_q[3], uw_q[4], uw_q[5]);
            vo_s = fir6(vw_q[0], vw_q[1], vw_q[2], vw_q[3], vw_q[4], vw_q[5]);
        end else begin
            uo_s = uw_q[2];
            vo_s = vw_q[2];
        end
    end

    // Filter stage: one full pair, drained even-then-odd into the multiply stage.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            f_valid_q <= 1'b0;
            f_phase_q <= 1'b0;
            f_last_q  <= 1'b0;
            f_ye_q    <= 8'd0;
            f_yo_q    <= 8'd0;
            f_ue_q    <= 8'd0;
            f_ve_q    <= 8'd0;
            f_uo_q    <= 8'd0;
            f_vo_q    <= 8'd0;
        end else if (f_load_s) begin
            f_valid_q <= 1'b1;
            f_phase_q <= 1'b0;
            f_last_q  <= (state_q == S_FLUSH) && (fl_q == 2'd3);
            f_ye_q    <= yew_q[0];
            f_yo_q    <= yow_q[0];
            f_ue_q    <= uw_q[2];
            f_ve_q    <= vw_q[2];
            f_uo_q    <= uo_s;
            f_vo_q    <= vo_s;
        end else if (m_load_s) begin
            f_phase_q <= !f_phase_q;
            f_valid_q <= !f_phase_q;
        end else begin
            f_valid_q <= f_valid_q;
        end
    end

    // Pixel operand selection and offset removal.
    always_comb begin
        sel_y_s = f_phase_q ? f_yo_q : f_ye_q;
        sel_u_s = f_phase_q ? f_uo_q : f_ue_q;
        sel_v_s = f_phase_q ? f_vo_q : f_ve_q;
        yd_s    = $signed({24'd0, sel_y_s}) - 32'sd16;
        ud_s    = $signed({24'd0, sel_u_s}) - 32'sd128;
        vd_s    = $signed({24'd0, sel_v_s}) - 32'sd128;
    end

    // Multiply stage.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_yc_q    <= 32'sd0;
            m_rv_q    <= 32'sd0;
            m_gu_q    <= 32'sd0;
            m_gv_q    <= 32'sd0;
            m_bu_q    <= 32'sd0;
        end else if (m_load_s) begin
            m_valid_q <= 1'b1;
            m_last_q  <= f_last_q && f_phase_q;
            m_yc_q    <= 32'sd76284 * yd_s;
            m_rv_q    <= 32'sd104595 * vd_s;
            m_gu_q    <= 32'sd25624 * ud_s;
            m_gv_q    <= 32'sd53281 * vd_s;
            m_bu_q    <= 32'sd132251 * ud_s;
        end else if (o_adv_s) begin
            m_valid_q <= 1'b0;
        end else begin
            m_valid_q <= m_valid_q;
        end
    end

    // Sum, shift and saturate into the output registers; held while stalled.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_r_q     <= 8'd0;
            out_g_q     <= 8'd0;
            out_b_q     <= 8'd0;
        end else if (o_adv_s) begin
            out_valid_q <= m_valid_q;
            out_last_q  <= m_valid_q && m_last_q;
            if (m_valid_q) begin
                out_r_q <= clip8((m_yc_q + m_rv_q) >>> 16);
                out_g_q <= clip8((m_yc_q - m_gu_q - m_gv_q) >>> 16);
                out_b_q <= clip8((m_yc_q + m_bu_q) >>> 16);
            end else begin
                out_r_q <= out_r_q;
            end
        end else begin
            out_valid_q <= out_valid_q;
        end
    end
endmodule

// File: tb/tb_yuv_upsample_csc.sv
// Bench for yuv_upsample_csc: an interpolating and a non-interpolating instance
// are checked against a per-row arithmetic model of the upsampling and conversion.
module tb_yuv_upsample_csc;
    localparam int LP   = 64;
    localparam int NPIX = 2 * LP;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic in_valid1 = 1'b0, in_valid0 = 1'b0, out_ready = 1'b1;
    logic in_ready1, in_ready0;
    logic [7:0] in_y_even = 8'd0, in_y_odd = 8'd0, in_u = 8'd0, in_v = 8'd0;
    logic out_valid1, out_last1, out_valid0, out_last0;
    logic [7:0] out_r1, out_g1, out_b1, out_r0, out_g0, out_b0;

    int nvec = 0, nfail = 0;
    int ya [NPIX];
    int ua [LP];
    int va [LP];
    logic [24:0] q1 [$];
    logic [24:0] q0 [$];
    logic [24:0] cap1 [NPIX];
    logic [24:0] cap0 [NPIX];
    int pi1 = 0, pi0 = 0, lasts1 = 0, lasts0 = 0;
    bit bp_en = 1'b0;

    always #5 Clock = ~Clock;

    yuv_upsample_csc #(.LINE_PAIRS(LP), .INTERP(1)) dut1 (
        .Clock(Clock), .Reset(Reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_y_even(in_y_even), .in_y_odd(in_y_odd), .in_u(in_u), .in_v(in_v),
        .out_valid(out_valid1), .out_ready(out_ready), .out_r(out_r1), .out_g(out_g1),
        .out_b(out_b1), .out_last(out_last1));

    yuv_upsample_csc #(.LINE_PAIRS(LP), .INTERP(0)) dut0 (
        .Clock(Clock), .Reset(Reset), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_y_even(in_y_even), .in_y_odd(in_y_odd), .in_u(in_u), .in_v(in_v),
        .out_valid(out_valid0), .out_ready(out_ready), .out_r(out_r0), .out_g(out_g0),
        .out_b(out_b0), .out_last(out_last0));

    function automatic int clip8(input int x);
        return (x < 0) ? 0 : ((x > 255) ? 255 : x);
    endfunction

    function automatic int samp(input bit isv, input int k);
        int c;
        c = (k < 0) ? 0 : ((k > LP - 1) ? LP - 1 : k);
        return isv ? va[c] : ua[c];
    endfunction

    function automatic int upc(input bit isv, input int p, input bit interp);
        int k;
        k = p / 2;
        if ((p % 2 == 0) || !interp) return samp(isv, k);
        return clip8((21 * (samp(isv, k - 2) + samp(isv, k + 3))
                    - 52 * (samp(isv, k - 1) + samp(isv, k + 2))
                    + 159 * (samp(isv, k) + samp(isv, k + 1)) + 128) >>> 8);
    endfunction

    function automatic logic [24:0] pix(input int p, input bit interp);
        int y, u, v, r, g, b;
        logic [24:0] res;
        y = ya[p] - 16;
        u = upc(1'b0, p, interp) - 128;
        v = upc(1'b1, p, interp) - 128;
        r = clip8((76284 * y + 104595 * v) >>> 16);
        g = clip8((76284 * y - 25624 * u - 53281 * v) >>> 16);
        b = clip8((76284 * y + 132251 * u) >>> 16);
        res = {(p == NPIX - 1), 8'(r), 8'(g), 8'(b)};
        return res;
    endfunction

    task automatic check(input string name, input int got, input int want);
        nvec++;
        if (got != want) begin
            nfail++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic chk(input bit which, input logic v, input logic lst,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        logic [24:0] got, exp;
        int idx;
        if (v && out_ready) begin
            got = {lst, r, g, b};
            idx = which ? pi1 : pi0;
            if (idx < NPIX) begin
                if (which) cap1[idx] = got;
                else cap0[idx] = got;
            end
            nvec++;
            if (which ? (q1.size() == 0) : (q0.size() == 0)) begin
                nfail++;
                $display("FAIL interp%0d extra pixel got=%h", which, got);
            end else begin
                exp = which ? q1.pop_front() : q0.pop_front();
                if (got !== exp) begin
                    nfail++;
                    $display("FAIL interp%0d pixel %0d got=%h want=%h", which, idx, got, exp);
                end
            end
            if (lst) begin
                idx = 0;
                if (which) lasts1++;
                else lasts0++;
            end else begin
                idx++;
            end
            if (which) pi1 = idx;
            else pi0 = idx;
        end
    endtask

    initial forever begin
        @(negedge Clock);
        if (!Reset) begin
            chk(1'b1, out_valid1, out_last1, out_r1, out_g1, out_b1);
            chk(1'b0, out_valid0, out_last0, out_r0, out_g0, out_b0);
        end
    end

    initial forever begin
        @(posedge Clock);
        #1;
        out_ready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    task automatic fill_const(input int y, input int u, input int v);
        for (int p = 0; p < NPIX; p++) ya[p] = y;
        for (int k = 0; k < LP; k++) begin
            ua[k] = u;
            va[k] = v;
        end
    endtask

    task automatic fill_rand();
        for (int p = 0; p < NPIX; p++) ya[p] = $urandom_range(0, 255);
        for (int k = 0; k < LP; k++) begin
            ua[k] = $urandom_range(0, 255);
            va[k] = $urandom_range(0, 255);
        end
    endtask

    task automatic push_row();
        for (int p = 0; p < NPIX; p++) begin
            q1.push_back(pix(p, 1'b1));
            q0.push_back(pix(p, 1'b0));
        end
    endtask

    // Entered and left at posedge+1.
    task automatic send_pair(input int k, input bit gaps);
        int budget;
        bit a1, a0;
        if (gaps) repeat ($urandom_range(0, 2)) begin
            @(posedge Clock);
            #1;
        end
        in_y_even = 8'(ya[2 * k]);
        in_y_odd  = 8'(ya[2 * k + 1]);
        in_u      = 8'(ua[k]);
        in_v      = 8'(va[k]);
        in_valid1 = 1'b1;
        in_valid0 = 1'b1;
        budget    = 0;
        while ((in_valid1 || in_valid0) && budget < 200) begin
            @(negedge Clock);
            a1 = in_valid1 && in_ready1;
            a0 = in_valid0 && in_ready0;
            @(posedge Clock);
            #1;
            if (a1) in_valid1 = 1'b0;
            if (a0) in_valid0 = 1'b0;
            budget++;
        end
        if (budget >= 200) begin
            nvec++;
            nfail++;
            $display("FAIL accept_timeout pair %0d got=stalled want=accepted", k);
            in_valid1 = 1'b0;
            in_valid0 = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while ((q1.size() != 0 || q0.size() != 0) && budget < 5000) begin
            @(posedge Clock);
            #1;
            budget++;
        end
        check("drain_left1", q1.size(), 0);
        check("drain_left0", q0.size(), 0);
    endtask

    task automatic run_row(input bit gaps);
        push_row();
        for (int k = 0; k < LP; k++) send_pair(k, gaps);
        wait_drain();
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_in_ready"}, int'(in_ready1) + int'(in_ready0), 0);
        check({name, "_out_valid"}, int'(out_valid1) + int'(out_valid0), 0);
        check({name, "_out_last"}, int'(out_last1) + int'(out_last0), 0);
        check({name, "_rgb"}, int'({out_r1, out_g1, out_b1}) | int'({out_r0, out_g0, out_b0}), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge Clock);
        #1;
        check_zero_outputs("reset");
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        check("ready_after_reset", int'(in_ready1) + int'(in_ready0), 2);

        // Mid-grey: every pixel 130, single out_last.
        fill_const(128, 128, 128);
        run_row(1'b0);
        check("grey_r0", int'(cap1[0][23:16]), 130);
        check("grey_b_last", int'(cap1[NPIX-1][7:0]), 130);
        check("grey_last_flag", int'(cap1[NPIX-1][24]), 1);
        check("grey_first_not_last", int'(cap1[0][24]), 0);
        check("grey_lasts", lasts1, 1);

        fill_const(16, 128, 128);
        run_row(1'b0);
        check("black_rgb", int'(cap1[5][23:0]), 0);

        fill_const(235, 128, 128);
        run_row(1'b0);
        check("white_r", int'(cap1[7][23:16]), 254);
        check("white_b", int'(cap1[7][7:0]), 254);

        // Saturation: first half bright red-heavy, second half dark with V=0.
        fill_const(16, 128, 0);
        for (int k = 0; k < LP / 2; k++) begin
            ya[2 * k] = 255;
            ya[2 * k + 1] = 255;
            va[k] = 255;
        end
        run_row(1'b0);
        check("sat_hi_r", int'(cap1[0][23:16]), 255);
        check("sat_lo_r", int'(cap1[NPIX-1][23:16]), 0);

        // Chroma impulse at U[5].
        fill_const(16, 128, 128);
        ua[5] = 228;
        check("model_u9_interp", upc(1'b0, 9, 1'b1), 190);
        check("model_u10_interp", upc(1'b0, 10, 1'b1), 228);
        check("model_u9_repl", upc(1'b0, 9, 1'b0), 128);
        run_row(1'b0);
        check("imp_b9_interp", int'(cap1[9][7:0]), 125);
        check("imp_b10_interp", int'(cap1[10][7:0]), 201);
        check("imp_b9_repl", int'(cap0[9][7:0]), 0);
        check("imp_b10_repl", int'(cap0[10][7:0]), 201);

        // Backpressure and input gaps over three rows.
        bp_en = 1'b1;
        repeat (3) begin
            fill_rand();
            run_row(1'b1);
        end
        check("lasts_interp", lasts1, 8);
        check("lasts_repl", lasts0, 8);

        // Abort a row after 50 pairs.
        fill_rand();
        push_row();
        for (int k = 0; k < 50; k++) send_pair(k, 1'b1);
        Reset = 1'b1;
        #1;
        check_zero_outputs("abort");
        q1.delete();
        q0.delete();
        pi1 = 0;
        pi0 = 0;
        repeat (3) @(posedge Clock);
        #1;
        Reset = 1'b0;
        fill_rand();
        run_row(1'b1);
        bp_en = 1'b0;
        repeat (20) @(posedge Clock);
        #1;
        check("lasts_after_abort1", lasts1, 9);
        check("lasts_after_abort0", lasts0, 9);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
